// File: rtl/chacha20_keystream_xor.sv
// ChaCha20 feed-forward stage: adds the original state to the post-round state and
// XORs the resulting 512-bit keystream onto a 32-bit plaintext stream.
module chacha20_keystream_xor (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_init,
    input  logic [511:0] blk_mix,
    input  logic         pt_valid,
    output logic         pt_ready,
    input  logic [31:0]  pt_data,
    input  logic         pt_last,
    output logic         ct_valid,
    input  logic         ct_ready,
    output logic [31:0]  ct_data,
    output logic         ct_last,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    state_t       state;
    logic [511:0] init_q;
    logic [511:0] mix_q;
    logic [31:0]  ks [16];
    logic [3:0]   idx;
    logic         pt_fire;
    logic         ct_accept;

    assign blk_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign pt_ready  = (state == STREAM) && (!ct_valid || ct_ready);
    assign pt_fire   = pt_valid && pt_ready;
    assign ct_accept = ct_valid && ct_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            init_q   <= '0;
            mix_q    <= '0;
            idx      <= '0;
            ct_valid <= 1'b0;
            ct_data  <= '0;
            ct_last  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                ks[i] <= '0;
            end
        end else begin
            // A new fire reloads the output register even while the old word is being accepted.
            if (pt_fire) begin
                ct_data  <= pt_data ^ ks[idx];
                ct_last  <= pt_last;
                ct_valid <= 1'b1;
            end else if (ct_accept) begin
                ct_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        init_q <= blk_init;
                        mix_q  <= blk_mix;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // Each word wraps independently; no carry crosses word boundaries.
                    for (int i = 0; i < 16; i++) begin
                        ks[i] <= init_q[32*i +: 32] + mix_q[32*i +: 32];
                    end
                    idx   <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (pt_fire) begin
                        idx <= idx + 4'd1;
                        if (idx == 4'd15 || pt_last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/chacha20_keystream_xor.md
# chacha20_keystream_xor

Downstream stage of the ChaCha20 round datapath. It accepts one 16-word block: the original input state plus the state after 20 rounds (10 double rounds of column/diagonal quarterrounds). It performs the final feed-forward addition, buffers the resulting 512-bit keystream, and XORs it word-by-word onto a 32-bit plaintext stream to produce ciphertext. It sits between the round engine and the byte/word output interface of the cipher.

## Interface
- No parameters. Block width is fixed at 16 × 32 bits; stream width is fixed at 32 bits.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `blk_valid` in 1: `blk_init` and `blk_mix` are valid.
- `blk_ready` out 1: block accepted when `blk_valid && blk_ready`.
- `blk_init` in 512: original state; word i is at [32i+31:32i].
- `blk_mix` in 512: post-round state, same packing.
- `pt_valid` in 1: plaintext word valid.
- `pt_ready` out 1: plaintext word consumed when `pt_valid && pt_ready`.
- `pt_data` in 32: plaintext word, little-endian bytes (byte 0 in [7:0]).
- `pt_last` in 1: final word of the message.
- `ct_valid` out 1: ciphertext word valid.
- `ct_ready` in 1: downstream accepts.
- `ct_data` out 32: ciphertext word.
- `ct_last` out 1: copy of `pt_last` for this word.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, LOAD, STREAM. Reset state is IDLE.
- **IDLE**
  - `blk_ready` = 1 (combinational from state).
  - On a block handshake, register `blk_init` and `blk_mix`, then go to LOAD.
- **LOAD**
  - `ks[i] = blk_init[i] + blk_mix[i]` mod 2^32, for all 16 words in parallel.
  - No carry propagates between words.
  - Result is registered into the keystream buffer. Word index `idx` is cleared to 0. Go to STREAM.
- **STREAM**
  - `pt_ready = !ct_valid || ct_ready`.
  - On a plaintext fire: `ct_data <= pt_data ^ ks[idx]`, `ct_last <= pt_last`, `ct_valid <= 1`, `idx <= idx + 1`.
  - If `idx == 15` or `pt_last` is set, go to IDLE on the same edge.
- **Output register**
  - If `ct_valid && ct_ready` and there is no new fire, `ct_valid <= 0`.
  - A simultaneous accept and fire loads the new word and keeps `ct_valid` = 1.
- **Boundary behaviour**
  - Early `pt_last`: the unused keystream words are discarded and never reused. The next message starts from word 0 of a new block.
  - `blk_valid` outside IDLE is ignored and not acknowledged.
  - Pending ciphertext may still be held in the output register in IDLE/LOAD. It drains normally.
  - `pt_ready` = 0 in IDLE and LOAD.
  - Reset at any time returns to IDLE and drops any in-flight `ct` word and any buffered keystream.
- **Reset values**
  - `ct_valid` = 0, `ct_data` = 0, `ct_last` = 0, `pt_ready` = 0, `busy` = 0.
  - `blk_ready` = 1, since state = IDLE.
  - Keystream buffer and `idx` = 0.

## Timing
- Block accepted at edge T. LOAD occupies cycle T+1. `pt_ready` can be 1 from cycle T+2.
- Plaintext-to-ciphertext latency: `ct_valid` rises one cycle after the plaintext fire.
- Throughput: 1 word/cycle while `pt_valid` and `ct_ready` are held high.
- Full 16-word block with no stalls:
  - Plaintext fires at T+2 … T+17.
  - `blk_ready` is high again in cycle T+18.
  - The last `ct` word is valid in cycle T+18.
- Minimum block period: 18 cycles (accept + LOAD + 16 stream cycles).
- No combinational path from `ct_ready` to `ct_data`. `pt_ready` depends combinationally on `ct_ready`.

## Test plan
1. **RFC 7539 §2.3.2 vector.** Drive `blk_init` = setup state (word 0 = 0x61707865) and `blk_mix` = 20-round state (word 0 = 0x837778ab). Send 16 plaintext words of 0x00000000 with `pt_last` on word 15, `ct_ready` = 1.
   - `ct` words equal the RFC serialized block: 0xe4e7f110, 0x15593bd1, … .
   - `ct_last` is set only on word 15.
   - `blk_ready` returns to 1 at T+18.
2. **Per-word wrap.** Set `init[3]` = 0xFFFFFFFF, `mix[3]` = 0x00000002, all other words 0. Plaintext word 3 = 0xA5A5A5A5.
   - `ct` word 3 = 0xA5A5A5A4; word 4 is unaffected (no carry).
3. **Backpressure.** Toggle `ct_ready` 1,0,1,0 with `pt_valid` held high.
   - Exactly 16 `ct` words in order, no duplicates or drops.
   - `pt_ready` = 0 whenever `ct_valid && !ct_ready`.
4. **Early `pt_last`.** Assert `pt_last` on word 5.
   - `ct_last` is set on the 6th `ct` word; state returns to IDLE.
   - The next block's first `ct` word uses `ks[0]` of the new block.
5. **Reset mid-stream.** Assert `rst_n` = 0 after 7 words.
   - Outputs go immediately to their reset values, `blk_ready` = 1.
   - After release, a new block streams correctly from word 0.
6. **Ignored block.** Pulse `blk_valid` during STREAM.
   - `blk_ready` stays 0 and the keystream is unchanged; `ct` output matches scenario 1.
